alu_exec: RTL and testbench

Execute stage of the 8-bit datapath, directly downstream of `alu_regs`. It latches the two operands read from `alu_regs` (`data_out_a`/`data_out_b`), performs one of eight operations, and writes the result back to `alu_regs` through `data_in`, `wrt_slct` and `wrtnbl`. Single-cycle ops and iterative shift/multiply share one FSM. Status flags (Z, C, N) are registered and update on the same clock edge as the write-back.

---
 rtl/alu_exec.sv | 189 ++++++++++++++++++
 tb/tb_alu_exec.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: 8-bit execute stage with shared FSM for single-cycle,
// iterative shift and shift-add multiply ops; registered write-back.
module alu_exec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] dst,
  input  logic [7:0] opnd_a,
  input  logic [7:0] opnd_b,
  output logic [7:0] data_in,
  output logic [6:0] wrt_slct,
  output logic       wrtnbl,
  output logic       busy,
  output logic       done,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  dst_q, dst_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  data_in_q, data_in_d;
  logic [6:0]  wrt_slct_q, wrt_slct_d;
  logic        pz_q, pz_d;
  logic        pc_q, pc_d;
  logic        pn_q, pn_d;
  logic        fz_q, fz_d;
  logic        fc_q, fc_d;
  logic        fn_q, fn_d;

  logic [7:0]  res;
  logic        cry;
  logic        fin;
  logic        accept;
  logic [15:0] addend;
  logic [15:0] prod;

  // Next-state, datapath iteration and result/flag staging
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dst_d      = dst_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    data_in_d  = data_in_q;
    wrt_slct_d = wrt_slct_q;
    pz_d       = pz_q;
    pc_d       = pc_q;
    pn_d       = pn_q;
    fz_d       = fz_q;
    fc_d       = fc_q;
    fn_d       = fn_q;
    res        = a_q;
    cry        = 1'b0;
    fin        = 1'b1;
    addend     = 16'h0000;
    prod       = 16'h0000;
    accept     = 1'b0;

    unique case (state_q)
      S_IDLE: accept = start;
      S_EXEC: begin
        case (op_q)
          OP_ADD: {cry, res} = {1'b0, a_q} + {1'b0, b_q};
          OP_SUB: begin
            res = a_q - b_q;
            cry = (a_q < b_q);
          end
          OP_AND: res = a_q & b_q;
          OP_OR:  res = a_q | b_q;
          OP_XOR: res = a_q ^ b_q;
          OP_SHL: begin
            if (b_q[2:0] != 3'd0) begin
              res   = {a_q[6:0], 1'b0};
              cry   = a_q[7];
              a_d   = res;
              cnt_d = cnt_q + 3'd1;
              fin   = (cnt_q == b_q[2:0] - 3'd1);
            end
          end
          OP_MUL: begin
            if (b_q[cnt_q])
              addend = {8'h00, a_q} << cnt_q;
            prod  = acc_q + addend;
            acc_d = prod;
            res   = prod[7:0];
            cry   = |prod[15:8];
            cnt_d = cnt_q + 3'd1;
            fin   = (cnt_q == 3'd7);
          end
          default: res = a_q;
        endcase
        if (fin) begin
          state_d    = S_WB;
          data_in_d  = res;
          wrt_slct_d = {4'b0000, dst_q};
          pz_d       = (res == 8'h00);
          pc_d       = cry;
          pn_d       = res[7];
        end
      end
      S_WB: begin
        fz_d    = pz_q;
        fc_d    = pc_q;
        fn_d    = pn_q;
        state_d = S_IDLE;
        accept  = start;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_EXEC;
      op_d    = op;
      dst_d   = dst;
      a_d     = opnd_a;
      b_d     = opnd_b;
      cnt_d   = 3'd0;
      acc_d   = 16'h0000;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      op_q       <= 3'd0;
      dst_q      <= 3'd0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      acc_q      <= 16'h0000;
      data_in_q  <= 8'h00;
      wrt_slct_q <= 7'd0;
      pz_q       <= 1'b0;
      pc_q       <= 1'b0;
      pn_q       <= 1'b0;
      fz_q       <= 1'b0;
      fc_q       <= 1'b0;
      fn_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      data_in_q  <= data_in_d;
      wrt_slct_q <= wrt_slct_d;
      pz_q       <= pz_d;
      pc_q       <= pc_d;
      pn_q       <= pn_d;
      fz_q       <= fz_d;
      fc_q       <= fc_d;
      fn_q       <= fn_d;
    end
  end

  assign data_in  = data_in_q;
  assign wrt_slct = wrt_slct_q;
  assign wrtnbl   = (state_q == S_WB);
  assign done     = (state_q == S_WB);
  assign busy     = (state_q != S_IDLE);
  assign flag_z   = fz_q;
  assign flag_c   = fc_q;
  assign flag_n   = fn_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec with directed and
// random ops checked against an arithmetic reference model.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] dst = 3'd0;
  logic [7:0] opnd_a = 8'h00;
  logic [7:0] opnd_b = 8'h00;
  logic [7:0] data_in;
  logic [6:0] wrt_slct;
  logic       wrtnbl, busy, done;
  logic       flag_z, flag_c, flag_n;

  alu_exec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dst(dst),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .data_in(data_in),
    .wrt_slct(wrt_slct), .wrtnbl(wrtnbl), .busy(busy), .done(done),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [6:0] s;
    logic [2:0] f;
    int         due;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic       fchk = 1'b0;
  logic [2:0] fexp = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the op definitions
  function automatic exp_t model(input logic [2:0] o, input logic [2:0] d,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input int now);
    exp_t e;
    logic [7:0]  r;
    logic        c;
    logic [15:0] p;
    int          sh;
    int          ex;
    c  = 1'b0;
    ex = 1;
    case (o)
      3'd0: begin p = 16'(a) + 16'(b); r = p[7:0]; c = p[8]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        sh = int'(b) % 8;
        p  = 16'(a) << sh;
        r  = p[7:0];
        c  = (sh == 0) ? 1'b0 : p[8];
        ex = (sh == 0) ? 1 : sh;
      end
      3'd6: begin
        p  = 16'(a) * 16'(b);
        r  = p[7:0];
        c  = (p[15:8] != 8'h00);
        ex = 8;
      end
      default: r = a;
    endcase
    e.d   = r;
    e.s   = {4'b0000, d};
    e.f   = {(r == 8'h00), c, r[7]};
    e.lat = ex + 1;
    e.due = now + ex + 1;
    return e;
  endfunction

  // Monitor: pop and compare on every write-back pulse
  always @(negedge clk) begin
    exp_t e;
    if (fchk) begin
      fchk = 1'b0;
      chk("flags_zcn", {flag_z, flag_c, flag_n}, fexp);
    end
    if (done !== wrtnbl)
      chk("done_eq_wrtnbl", done, wrtnbl);
    if (wrtnbl) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("data_in", data_in, e.d);
        chk("wrt_slct", wrt_slct, e.s);
        chk("write_cycle", cyc, e.due);
        fexp = e.f;
        fchk = 1'b1;
      end
    end
  end

  // Called at posedge+1: present a request and log its expectation
  task automatic drive(input logic [2:0] o, input logic [2:0] d,
                       input logic [7:0] a, input logic [7:0] b,
                       output int lat);
    exp_t e;
    op     = o;
    dst    = d;
    opnd_a = a;
    opnd_b = b;
    start  = 1'b1;
    e      = model(o, d, a, b, cyc);
    lat    = e.lat;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [2:0] d,
                        input logic [7:0] a, input logic [7:0] b);
    int n;
    int lat;
    wait_idle();
    drive(o, d, a, b, lat);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_len", n, lat);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_in"}, data_in, 0);
    chk({tag, "_wrt_slct"}, wrt_slct, 0);
    chk({tag, "_ctl"}, {wrtnbl, done, busy}, 0);
    chk({tag, "_flags"}, {flag_z, flag_c, flag_n}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(3'd0, 3'd6, 8'h01, 8'h05);
    run_op(3'd0, 3'd1, 8'hFF, 8'h01);
    run_op(3'd1, 3'd2, 8'h03, 8'h05);
    run_op(3'd6, 3'd3, 8'h10, 8'h11);
    run_op(3'd6, 3'd4, 8'h0C, 8'h0A);
    run_op(3'd5, 3'd5, 8'h81, 8'h0B);
    run_op(3'd5, 3'd7, 8'h81, 8'h00);
    run_op(3'd2, 3'd0, 8'hF0, 8'h3C);
    run_op(3'd3, 3'd1, 8'hF0, 8'h0F);
    run_op(3'd4, 3'd2, 8'hAA, 8'hAA);
    run_op(3'd7, 3'd3, 8'h80, 8'h12);
    run_op(3'd5, 3'd4, 8'hC3, 8'h07);

    // Start during MUL exec is ignored; operand change has no effect
    wait_idle();
    drive(3'd6, 3'd5, 8'h0C, 8'h0A, lat);
    @(posedge clk); #1;
    start  = 1'b0;
    opnd_a = 8'hFF;
    @(posedge clk); #1;
    op     = 3'd0;
    dst    = 3'd1;
    opnd_b = 8'h33;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_idle();

    // Back-to-back: second start sampled on the WB->IDLE edge
    drive(3'd0, 3'd2, 8'h10, 8'h20, lat);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    drive(3'd1, 3'd3, 8'h20, 8'h30, lat);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Reset in the 4th MUL exec cycle aborts the op
    drive(3'd6, 3'd6, 8'h37, 8'h5B, lat);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sbq.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_zero("midreset");
    repeat (12) @(posedge clk);
    #1;
    chk_zero("post_abort");
    run_op(3'd0, 3'd6, 8'h01, 8'h05);

    // Random ops with random idle gaps
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 2);
      repeat (n) @(posedge clk);
      #1;
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             8'($urandom), 8'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
